// File: rtl/csela_rr_scheduler_pkg.sv
// Shared constants and types for the round-robin adder scheduler.
// The optional per-lane grant statistics are enabled with CSELA_RR_STATS_EN.
package csela_sched_pkg;

    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_ADDER_WIDTH = 8;

    localparam int unsigned           STATS_W   = 16;
    localparam logic [STATS_W-1:0]    STATS_MAX = '1;

    typedef enum logic {
        IDLE,
        FULL
    } sched_state_e;

endpackage

// File: rtl/csela_rr_scheduler_if.sv
// Request/response channel between the partial-product lanes and the scheduler.
// master = lane/accumulator side, slave = scheduler side.
interface csela_rr_scheduler_if
    import csela_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*ADDER_WIDTH-1:0] req_operand;
    logic [NUM_REQ-1:0]             req_carry;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [ADDER_WIDTH-1:0]         rsp_sum;
    logic                           rsp_wrap;
    logic [ID_W-1:0]                rsp_id;

    modport master (
        output req_valid, req_operand, req_carry, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_wrap, rsp_id
    );

    modport slave (
        input  req_valid, req_operand, req_carry, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_wrap, rsp_id
    );

endinterface

// File: rtl/carray_select_adder.sv
// Carry-select incrementer: adds a single carry-in to an operand, upper half precomputed
// for both incoming carries.
module carray_select_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int unsigned LO_W = WIDTH / 2;
    localparam int unsigned HI_W = WIDTH - LO_W;

    logic [LO_W:0]   w_lo;
    logic [HI_W-1:0] w_hi0;
    logic [HI_W:0]   w_hi1;

    assign w_lo  = {1'b0, i_a[LO_W-1:0]} + {{LO_W{1'b0}}, i_cin};
    assign w_hi0 = i_a[WIDTH-1:LO_W];
    assign w_hi1 = {1'b0, i_a[WIDTH-1:LO_W]} + {{HI_W{1'b0}}, 1'b1};

    assign o_sum  = {(w_lo[LO_W] ? w_hi1[HI_W-1:0] : w_hi0), w_lo[LO_W-1:0]};
    assign o_cout = w_lo[LO_W] & w_hi1[HI_W];

endmodule

// File: rtl/csela_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);
    logic [ID_W-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            w_j = ID_W'((int'(i_ptr) + k) % int'(NUM_REQ));
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/csela_rr_scheduler.sv
// Shares one carry-select incrementer among NUM_REQ lanes, round-robin, with a
// one-deep registered response slot. CSELA_RR_STATS_EN adds per-lane grant counters.
module csela_rr_scheduler
    import csela_sched_pkg::*;
#(
    parameter int unsigned ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef CSELA_RR_STATS_EN
    input  logic                         stats_clr,
    output logic [NUM_REQ*STATS_W-1:0]   grant_count,
`endif
    csela_rr_scheduler_if.slave          bus
);
    sched_state_e           r_state, w_state_nxt;
    logic [ID_W-1:0]        r_ptr, r_id, w_idx;
    logic [ADDER_WIDTH-1:0] r_sum, w_operand, w_sum;
    logic                   r_wrap, w_carry, w_cout;
    logic                   w_slot_free, w_accept, w_any;
    logic [NUM_REQ-1:0]     w_gnt, w_req_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Slot frees in the same cycle the held response drains, giving full throughput.
    assign w_slot_free = (r_state == IDLE) || bus.rsp_ready;
    assign w_req_ready = w_gnt & {NUM_REQ{w_slot_free & rst_n}};
    assign w_accept    = w_any & |(bus.req_valid & w_req_ready);

    assign w_operand = bus.req_operand[w_idx*ADDER_WIDTH +: ADDER_WIDTH];
    assign w_carry   = bus.req_carry[w_idx];

    carray_select_adder #(
        .WIDTH (ADDER_WIDTH)
    ) u_add (
        .i_a    (w_operand),
        .i_cin  (w_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = FULL;
            FULL:    if (bus.rsp_ready && !w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_wrap  <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_sum  <= w_sum;
                r_wrap <= w_cout;
                r_id   <= w_idx;
                r_ptr  <= (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state == FULL);
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_wrap  = r_wrap;
    assign bus.rsp_id    = r_id;

`ifdef CSELA_RR_STATS_EN
    for (genvar gi = 0; gi < int'(NUM_REQ); gi++) begin : g_stats
        logic [STATS_W-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (stats_clr) begin
                r_cnt <= '0;
            end else if (w_accept && (w_idx == ID_W'(gi)) && (r_cnt != STATS_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign grant_count[gi*STATS_W +: STATS_W] = r_cnt;
    end
`endif

endmodule
